// File: rtl/mem_port_arbiter.sv
// N-port round-robin arbiter with bounded same-port bursts in front of one single-transaction memory backend.
// Define MEM_ARB_PRIORITY_EN to give port 0 unconditional priority in IDLE.
module mem_port_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS-1:0]          req_rw,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic [NUM_PORTS-1:0]          rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          mem_as,
    output logic                          mem_rw,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_done
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    logic [PW-1:0]          r_rr_ptr;
    logic [BW-1:0]          r_burst_cnt;
    logic [PW-1:0]          r_owner;
    logic                   r_last_own;
    logic [PW-1:0]          r_gnt;
    logic                   r_mem_as;
    logic                   r_mem_rw;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic [DATA_W-1:0]      r_mem_wdata;
    logic [NUM_PORTS-1:0]   r_rsp_valid;
    logic [DATA_W-1:0]      r_rsp_rdata;

    logic                   w_any;
    logic                   w_prio;
    logic                   w_burst_hit;
    logic                   w_accept;
    logic [PW-1:0]          w_rr_gnt;
    logic [PW-1:0]          w_gnt;
    logic [PW-1:0]          w_gnt_next;

    // First requester at or after ptr, wrapping; lowest offset wins.
    function automatic logic [PW-1:0] rr_pick(input logic [NUM_PORTS-1:0] v,
                                              input logic [PW-1:0] ptr);
        logic [PW-1:0] pick;
        int            idx;
        pick = ptr;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_PORTS;
            if (v[idx]) pick = PW'(idx);
        end
        return pick;
    endfunction

    always_comb begin
        w_any       = |req_valid;
`ifdef MEM_ARB_PRIORITY_EN
        w_prio      = req_valid[0];
`else
        w_prio      = 1'b0;
`endif
        w_burst_hit = r_last_own && req_valid[r_owner] && (int'(r_burst_cnt) < MAX_BURST - 1);
        w_rr_gnt    = rr_pick(req_valid, r_rr_ptr);
        if (w_prio)
            w_gnt = '0;
        else if (w_burst_hit)
            w_gnt = r_owner;
        else
            w_gnt = w_rr_gnt;
        w_gnt_next  = (int'(w_gnt) == NUM_PORTS - 1) ? '0 : w_gnt + PW'(1);
        w_accept    = (r_state == S_IDLE) && w_any && !rst;
        req_ready   = w_accept ? (NUM_PORTS'(1) << w_gnt) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_owner     <= '0;
            r_last_own  <= 1'b0;
            r_gnt       <= '0;
            r_mem_as    <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt       <= w_gnt;
                        r_mem_as    <= 1'b1;
                        r_mem_rw    <= req_rw[w_gnt];
                        r_mem_addr  <= req_addr[int'(w_gnt)*ADDR_W +: ADDR_W];
                        r_mem_wdata <= req_wdata[int'(w_gnt)*DATA_W +: DATA_W];
                        r_state     <= S_BUSY;
                        // A priority grant breaks the owner's streak without touching RR state.
                        if (w_prio) begin
                            r_last_own <= 1'b0;
                        end else begin
                            r_burst_cnt <= w_burst_hit ? r_burst_cnt + BW'(1) : '0;
                            r_owner     <= w_gnt;
                            r_last_own  <= 1'b1;
                            r_rr_ptr    <= w_gnt_next;
                        end
                    end
                end
                S_BUSY: begin
                    if (mem_done) begin
                        r_mem_as    <= 1'b0;
                        r_rsp_valid <= NUM_PORTS'(1) << r_gnt;
                        r_rsp_rdata <= r_mem_rw ? '0 : mem_rdata;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= '0;
                    r_rsp_rdata <= '0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_as    = r_mem_as;
    assign mem_rw    = r_mem_rw;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one DUT with MAX_BURST=4, one with MAX_BURST=1 on shared request inputs.
module tb_mem_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 23;
    localparam int DW = 16;

    typedef struct {
        int          port;
        logic [15:0] data;
    } rsp_t;

    logic             clk;
    logic             rst;
    logic [NP-1:0]    req_valid;
    logic [NP-1:0]    req_rw;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata;

    logic [NP-1:0]    rdy0, rspv0;
    logic [DW-1:0]    rspd0;
    logic             as0, rw0, done0;
    logic [AW-1:0]    addr0;
    logic [DW-1:0]    wd0, rd0;

    logic [NP-1:0]    rdy1, rspv1;
    logic [DW-1:0]    rspd1;
    logic             as1, rw1, done1;
    logic [AW-1:0]    addr1;
    logic [DW-1:0]    wd1, rd1;

    logic [DW-1:0]    mem0 [0:255];
    logic [DW-1:0]    mem1 [0:255];
    logic [DW-1:0]    sh   [0:255];
    int               cnt0, cnt1;

    int               gq[$];
    int               gq1[$];
    rsp_t             rq[$];
    int               n_chk;
    int               n_fail;

    logic             p_as, p_rw;
    logic [AW-1:0]    p_addr;
    logic [DW-1:0]    p_wd;

    mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(rdy0), .rsp_valid(rspv0), .rsp_rdata(rspd0),
        .mem_as(as0), .mem_rw(rw0), .mem_addr(addr0), .mem_wdata(wd0),
        .mem_rdata(rd0), .mem_done(done0));

    mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(rdy1), .rsp_valid(rspv1), .rsp_rdata(rspd1),
        .mem_as(as1), .mem_rw(rw1), .mem_addr(addr1), .mem_wdata(wd1),
        .mem_rdata(rd1), .mem_done(done1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backend models: done in the third cycle of the strobe, dropped as soon as the strobe falls.
    assign done0 = as0 && (cnt0 == 2);
    assign done1 = as1 && (cnt1 == 2);
    assign rd0   = mem0[addr0[7:0]];
    assign rd1   = mem1[addr1[7:0]];

    always @(posedge clk) begin
        if (!as0) cnt0 <= 0; else if (cnt0 < 3) cnt0 <= cnt0 + 1;
        if (!as1) cnt1 <= 0; else if (cnt1 < 3) cnt1 <= cnt1 + 1;
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= '0;
                mem1[i] <= '0;
            end
            mem0[16] <= 16'h00AB;
            mem1[16] <= 16'h00AB;
        end else begin
            if (done0 && rw0) mem0[addr0[7:0]] <= wd0;
            if (done1 && rw1) mem1[addr1[7:0]] <= wd1;
        end
    end

    // Per-cycle protocol checks and scoreboard pops.
    always @(negedge clk) begin
        int   e;
        rsp_t r;
        n_chk++;
        if (!$onehot0(rdy0) || !$onehot0(rdy1)) begin
            n_fail++;
            $display("FAIL ready_onehot: got %b / %b, required at most one bit", rdy0, rdy1);
        end
        n_chk++;
        if (!$onehot0(rspv0) || !$onehot0(rspv1)) begin
            n_fail++;
            $display("FAIL rsp_onehot: got %b / %b, required at most one bit", rspv0, rspv1);
        end
        n_chk++;
        if (rspv0 == '0 && rspd0 !== '0) begin
            n_fail++;
            $display("FAIL rdata_idle: got %h, required 0000", rspd0);
        end
        if (p_as === 1'b1 && as0 === 1'b1) begin
            n_chk++;
            if (rw0 !== p_rw || addr0 !== p_addr || wd0 !== p_wd) begin
                n_fail++;
                $display("FAIL mem_stable: got rw=%b addr=%h wd=%h, required rw=%b addr=%h wd=%h",
                         rw0, addr0, wd0, p_rw, p_addr, p_wd);
            end
        end
        p_as = as0; p_rw = rw0; p_addr = addr0; p_wd = wd0;
        if (rdy0 != '0 && gq.size() > 0) begin
            e = gq.pop_front();
            n_chk++;
            if (rdy0 !== (4'b0001 << e)) begin
                n_fail++;
                $display("FAIL grant: got req_ready=%b, required port %0d", rdy0, e);
            end
        end
        if (rdy1 != '0 && gq1.size() > 0) begin
            e = gq1.pop_front();
            n_chk++;
            if (rdy1 !== (4'b0001 << e)) begin
                n_fail++;
                $display("FAIL grant_rr: got req_ready=%b, required port %0d", rdy1, e);
            end
        end
        if (rspv0 != '0 && rq.size() > 0) begin
            r = rq.pop_front();
            n_chk++;
            if (rspv0 !== (4'b0001 << r.port) || rspd0 !== r.data) begin
                n_fail++;
                $display("FAIL response: got rsp_valid=%b rdata=%h, required port %0d rdata=%h",
                         rspv0, rspd0, r.port, r.data);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic issue(input int p, input bit rw, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit exp_rsp);
        rsp_t e;
        int   cnt;
        bit   acc;
        @(posedge clk); #1;
        req_rw[p]              = rw;
        req_addr[p*AW +: AW]   = a;
        req_wdata[p*DW +: DW]  = d;
        req_valid[p]           = 1'b1;
        gq.push_back(p);
        cnt = 0;
        acc = 1'b0;
        while (!acc && cnt < 50) begin
            @(negedge clk);
            if (rdy0[p]) acc = 1'b1; else cnt++;
        end
        n_chk++;
        if (!acc) begin
            n_fail++;
            $display("FAIL accept_timeout: port %0d got no req_ready within 50 cycles", p);
        end else if (exp_rsp) begin
            e.port = p;
            e.data = rw ? 16'h0000 : sh[a[7:0]];
            if (rw) sh[a[7:0]] = d;
            rq.push_back(e);
        end
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
    endtask

    // Holds the masked ports requesting (writes to 0x80+p) until the chosen grant queue drains.
    task automatic run_cont(input logic [NP-1:0] mask, input bit use1, output int cyc);
        for (int p = 0; p < NP; p++) begin
            req_rw[p]             = 1'b1;
            req_addr[p*AW +: AW]  = AW'(8'h80 + p);
            req_wdata[p*DW +: DW] = DW'(16'h5A00 + p);
        end
        @(posedge clk); #1;
        req_valid = mask;
        cyc = 0;
        while (((use1 ? gq1.size() : gq.size()) != 0) && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        #1 req_valid = '0;
        n_chk++;
        if (cyc >= 300) begin
            n_fail++;
            $display("FAIL cont_timeout: mask %b, %0d grants still pending", mask,
                     use1 ? gq1.size() : gq.size());
        end
        repeat (10) @(posedge clk);
    endtask

    task automatic push_exp(input int p);
        rsp_t e;
        gq.push_back(p);
        e.port = p;
        e.data = 16'h0000;
        rq.push_back(e);
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (rdy0 !== '0 || rdy1 !== '0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b / %b, required 0000", rdy0, rdy1);
        end
        n_chk++;
        if (rspv0 !== '0 || rspd0 !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp: got valid=%b rdata=%h, required 0", rspv0, rspd0);
        end
        n_chk++;
        if (as0 !== 1'b0 || rw0 !== 1'b0 || addr0 !== '0 || wd0 !== '0 || as1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mem: got as=%b rw=%b addr=%h wd=%h, required all 0", as0, rw0, addr0, wd0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_rr();
        int cyc;
        do_reset();
        gq1.push_back(0); gq1.push_back(1); gq1.push_back(2);
        gq1.push_back(3); gq1.push_back(0); gq1.push_back(1);
        run_cont(4'b1111, 1'b1, cyc);
    endtask

    task automatic test_burst();
        int cyc;
        do_reset();
        for (int i = 0; i < 4; i++) push_exp(0);
        for (int i = 0; i < 4; i++) push_exp(3);
        push_exp(0);
        run_cont(4'b1001, 1'b0, cyc);
    endtask

    task automatic test_priority();
        int cyc;
        do_reset();
        for (int i = 0; i < 5; i++) push_exp(0);
        for (int p = 0; p < NP; p++) begin
            req_rw[p]             = 1'b1;
            req_addr[p*AW +: AW]  = AW'(8'h80 + p);
            req_wdata[p*DW +: DW] = DW'(16'h5A00 + p);
        end
        @(posedge clk); #1;
        req_valid = 4'b0101;
        cyc = 0;
        while (gq.size() != 0 && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        #1 req_valid = 4'b0100;
        push_exp(2);
        while (gq.size() != 0 && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        #1 req_valid = '0;
        n_chk++;
        if (cyc >= 300) begin
            n_fail++;
            $display("FAIL prio_timeout: %0d grants still pending", gq.size());
        end
        repeat (10) @(posedge clk);
    endtask

    task automatic test_single_read();
        issue(2, 1'b0, AW'(16'h0010), 16'h0000, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_chk++;
            if (as0 !== 1'b1 || rw0 !== 1'b0 || addr0 !== AW'(16'h0010) || rspv0 !== '0) begin
                n_fail++;
                $display("FAIL read_busy_T%0d: got as=%b rw=%b addr=%h rsp=%b, required as=1 rw=0 addr=10 rsp=0",
                         k, as0, rw0, addr0, rspv0);
            end
        end
        @(negedge clk);
        n_chk++;
        if (rspv0 !== 4'b0100 || rspd0 !== 16'h00AB || as0 !== 1'b0) begin
            n_fail++;
            $display("FAIL read_rsp_T4: got rsp=%b rdata=%h as=%b, required 0100 00ab 0", rspv0, rspd0, as0);
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_write_read();
        issue(1, 1'b1, AW'(5), 16'h1234, 1'b1);
        issue(1, 1'b0, AW'(5), 16'h0000, 1'b1);
        repeat (8) @(posedge clk);
        n_chk++;
        if (rq.size() != 0) begin
            n_fail++;
            $display("FAIL write_read_drain: got %0d pending responses, required 0", rq.size());
        end
    endtask

    task automatic test_single_port_burst();
        int cyc;
        for (int i = 0; i < 8; i++) push_exp(1);
        run_cont(4'b0010, 1'b0, cyc);
        n_chk++;
        if (cyc > 36) begin
            n_fail++;
            $display("FAIL burst_no_stall: got %0d cycles for 8 grants, required at most 36", cyc);
        end
    endtask

    task automatic test_reset_midop();
        int cyc;
        issue(2, 1'b0, AW'(16'h0010), 16'h0000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (as0 !== 1'b0 || rspv0 !== '0) begin
            n_fail++;
            $display("FAIL abort_as: got as=%b rsp=%b, required 0 0", as0, rspv0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_chk++;
            if (rspv0 !== '0) begin
                n_fail++;
                $display("FAIL abort_rsp: got rsp_valid=%b, required 0000", rspv0);
            end
        end
        push_exp(1);
        run_cont(4'b1010, 1'b0, cyc);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        req_valid = '0;
        req_rw = '0;
        req_addr = '0;
        req_wdata = '0;
        p_as = 1'b0; p_rw = 1'b0; p_addr = '0; p_wd = '0;
        for (int i = 0; i < 256; i++) sh[i] = '0;
        sh[16] = 16'h00AB;

        test_reset();
`ifdef MEM_ARB_PRIORITY_EN
        test_priority();
`else
        test_rr();
        test_burst();
`endif
        test_single_read();
        test_write_read();
        test_single_port_burst();
        test_reset_midop();

        n_chk++;
        if (gq.size() != 0 || gq1.size() != 0 || rq.size() != 0) begin
            n_fail++;
            $display("FAIL final_drain: got %0d/%0d grants and %0d responses pending, required none",
                     gq.size(), gq1.size(), rq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
